// File: rtl/usart_receiver_if.sv
// Receive-side bundle between the USART front end and its consumer.
interface usart_receiver_if;
    logic [11:0] clocks_per_bit;
    logic        rx_pin;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        framing_error;
    logic        overrun_error;
    logic        busy;

    modport master (
        output clocks_per_bit, rx_pin, rx_ready,
        input  rx_data, rx_valid, framing_error, overrun_error, busy
    );

    modport slave (
        input  clocks_per_bit, rx_pin, rx_ready,
        output rx_data, rx_valid, framing_error, overrun_error, busy
    );
endinterface

// File: rtl/usart_receiver.sv
// 8N1 USART receiver: synchroniser, mid-bit sampling FSM, one-entry holding register.
//
// state   | meaning
// --------+-------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on the synchronised line
// S_START | counting to mid start bit, confirming it is still low
// S_DATA  | sampling 8 data bits LSB first, one per bit period
// S_STOP  | sampling the stop bit, delivering or flagging the byte
// S_BREAK | stop bit was low; waiting for the line to return high
module usart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_comm_clock,
    input  logic             i_reset_n,
    usart_receiver_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx_sync;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_cnt, w_cnt_nxt;
    logic [11:0] r_cpb, w_cpb_nxt;
    logic [2:0]  r_bit_idx, w_bit_idx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        w_deliver;
    logic        w_frame_err;

    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_framing_error;
    logic        r_overrun_error;

    assign w_rx_sync = r_sync[SYNC_STAGES-1];

    // Bring rx_pin into the clock domain and keep the previous value for edge detect.
    always_ff @(posedge i_comm_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.rx_pin};
            r_rx_prev <= w_rx_sync;
        end
    end

    // FSM state, bit timer, bit index, shift register and latched divider.
    always_ff @(posedge i_comm_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 12'd0;
            r_cpb     <= 12'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cpb     <= w_cpb_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state logic; a sample is taken in timed states when the timer reaches zero.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cpb_nxt     = r_cpb;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_deliver     = 1'b0;
        w_frame_err   = 1'b0;

        if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
            if (r_cnt != 12'd0) begin
                w_cnt_nxt = r_cnt - 12'd1;
            end else begin
                w_cnt_nxt = r_cpb - 12'd1;
            end
        end

        unique case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !w_rx_sync) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = bus.clocks_per_bit >> 1;
                    w_cpb_nxt   = bus.clocks_per_bit;
                end
            end
            S_START: begin
                if (r_cnt == 12'd0) begin
                    if (!w_rx_sync) begin
                        w_state_nxt   = S_DATA;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == 12'd0) begin
                    w_shift_nxt = {w_rx_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == 12'd0) begin
                    if (w_rx_sync) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx_sync) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Holding register with overrun detection; a same-cycle transfer frees the slot.
    always_ff @(posedge i_comm_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data          <= 8'd0;
            r_valid         <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            r_framing_error <= w_frame_err;
            r_overrun_error <= w_deliver && r_valid && !bus.rx_ready;
            if (w_deliver && (!r_valid || bus.rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = r_data;
    assign bus.rx_valid      = r_valid;
    assign bus.framing_error = r_framing_error;
    assign bus.overrun_error = r_overrun_error;
    assign bus.busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_usart_receiver.sv
// Self-checking bench for usart_receiver: directed vectors, corner sequences, random frames.
module tb_usart_receiver;

    logic clk;
    logic reset_n;
    usart_receiver_if bus();

    usart_receiver #(.SYNC_STAGES(2)) dut (
        .i_comm_clock (clk),
        .i_reset_n    (reset_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    logic [7:0] got_q[$];
    int valid_rise = 0, valid_hi = 0, rise_cyc = 0;
    int fe_cnt = 0, fe_wide = 0, ov_cnt = 0, ov_wide = 0, ov_cyc = 0;
    int busy_hi = 0;
    bit quiet = 0;
    int quiet_bad = 0;
    logic prev_v = 0, prev_fe = 0, prev_ov = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive observer, sampling on the falling edge.
    always @(negedge clk) begin
        if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
        if (bus.rx_valid && !prev_v) begin valid_rise++; rise_cyc = cyc; end
        if (bus.rx_valid) valid_hi++;
        if (bus.framing_error) begin fe_cnt++; if (prev_fe) fe_wide++; end
        if (bus.overrun_error) begin ov_cnt++; ov_cyc = cyc; if (prev_ov) ov_wide++; end
        if (bus.busy) busy_hi++;
        if (quiet && (bus.rx_valid || bus.busy || bus.framing_error ||
                      bus.overrun_error || bus.rx_data != 8'd0)) quiet_bad++;
        prev_v  = bus.rx_valid;
        prev_fe = bus.framing_error;
        prev_ov = bus.overrun_error;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] exp);
        if (got_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no byte received, expected %02h", name, exp);
        end else begin
            check(name, {24'd0, got_q.pop_front()}, {24'd0, exp});
        end
    endtask

    // Advance k falling edges and settle one time unit past the edge.
    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    // Drive one 8N1 frame with n cycles per bit; a low stop bit is extended by brk cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int n, input int brk);
        bus.clocks_per_bit = 12'(n);
        bus.rx_pin = 1'b0;
        t0 = cyc;
        wait_cyc(n);
        for (int i = 0; i < 8; i++) begin
            bus.rx_pin = d[i];
            wait_cyc(n);
        end
        bus.rx_pin = stop;
        wait_cyc(n);
        if (brk > 0) wait_cyc(brk);
        bus.rx_pin = 1'b1;
        wait_cyc(3);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         n;
        logic [7:0] exp_data;
        int         exp_bytes;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] exp_q[$];
    int exp_fe;
    int b0, f0, o0, v0, h0, bz0;

    initial begin
        vecs[0] = '{8'h75, 1'b1, 64,  8'h75, 1, 0};
        vecs[1] = '{8'h8A, 1'b1, 4,   8'h8A, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 5,   8'h00, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 17,  8'hFF, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 12,  8'h00, 0, 1};
        vecs[5] = '{8'h01, 1'b1, 100, 8'h01, 1, 0};

        reset_n = 1'b0;
        bus.rx_pin = 1'b0;
        bus.rx_ready = 1'b0;
        bus.clocks_per_bit = 12'd64;

        // Reset: everything quiet while held and for 2000 cycles after release.
        quiet = 1;
        wait_cyc(10);
        check("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_errors", {30'd0, bus.framing_error, bus.overrun_error}, 32'd0);
        bus.rx_pin = 1'b1;
        reset_n = 1'b1;
        wait_cyc(2000);
        quiet = 0;
        check("reset_quiet", quiet_bad, 0);

        // Single frame at N=64 with latency and pulse width.
        bus.rx_ready = 1'b1;
        got_q.delete();
        v0 = valid_rise; h0 = valid_hi; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h75, 1'b1, 64, 0);
        wait_cyc(4);
        check("single_rises", valid_rise - v0, 1);
        check("single_width", valid_hi - h0, 1);
        check_range("single_latency", rise_cyc - (t0 + 1), 610, 612);
        check_byte("single_data", 8'h75);
        check("single_errors", (fe_cnt - f0) + (ov_cnt - o0), 0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            b0 = got_q.size(); f0 = fe_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].n, 0);
            wait_cyc(2);
            check($sformatf("vec%0d_bytes", i), got_q.size() - b0, vecs[i].exp_bytes);
            if (vecs[i].exp_bytes != 0) check_byte($sformatf("vec%0d_data", i), vecs[i].exp_data);
            check($sformatf("vec%0d_fe", i), fe_cnt - f0, vecs[i].exp_fe);
        end

        // Overrun: second byte dropped while first is held.
        bus.rx_ready = 1'b0;
        o0 = ov_cnt;
        send_frame(8'h75, 1'b1, 64, 0);
        send_frame(8'h8A, 1'b1, 64, 0);
        check("ovr_pulses", ov_cnt - o0, 1);
        check_range("ovr_timing", ov_cyc - (t0 + 1), 610, 612);
        check("ovr_data_kept", {24'd0, bus.rx_data}, 32'h75);
        check("ovr_valid_held", {31'd0, bus.rx_valid}, 32'd1);
        bus.rx_ready = 1'b1;
        wait_cyc(1);
        check("ovr_valid_drop", {31'd0, bus.rx_valid}, 32'd0);
        got_q.delete();

        // Glitch rejection.
        bz0 = busy_hi; v0 = valid_rise; f0 = fe_cnt; o0 = ov_cnt;
        bus.rx_pin = 1'b0;
        wait_cyc(10);
        bus.rx_pin = 1'b1;
        wait_cyc(30);
        check("glitch_busy_seen", {31'd0, (busy_hi - bz0) > 0}, 32'd1);
        check("glitch_busy_end", {31'd0, bus.busy}, 32'd0);
        check("glitch_quiet", (valid_rise - v0) + (fe_cnt - f0) + (ov_cnt - o0), 0);

        // Framing error followed by a 20N break, then a good frame.
        v0 = valid_rise; f0 = fe_cnt;
        send_frame(8'h75, 1'b0, 64, 20 * 64);
        check("brk_fe", fe_cnt - f0, 1);
        check("brk_no_valid", valid_rise - v0, 0);
        check("brk_idle_after", {31'd0, bus.busy}, 32'd0);
        send_frame(8'h8A, 1'b1, 64, 0);
        wait_cyc(2);
        check_byte("brk_next_data", 8'h8A);

        // Reset during data bit 4, with a held byte present.
        bus.rx_ready = 1'b0;
        send_frame(8'h75, 1'b1, 64, 0);
        b0 = got_q.size();
        bus.clocks_per_bit = 12'd64;
        bus.rx_pin = 1'b0;
        wait_cyc(64);
        for (int i = 0; i < 4; i++) begin
            bus.rx_pin = (i == 1 || i == 3);
            wait_cyc(64);
        end
        bus.rx_pin = 1'b0;
        wait_cyc(32);
        reset_n = 1'b0;
        bus.rx_pin = 1'b1;
        wait_cyc(3);
        check("mid_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("mid_rst_data", {24'd0, bus.rx_data}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        reset_n = 1'b1;
        bus.rx_ready = 1'b1;
        wait_cyc(3 * 64);
        check("mid_rst_no_byte", got_q.size() - b0, 0);
        send_frame(8'h8A, 1'b1, 64, 0);
        wait_cyc(2);
        check_byte("mid_rst_next", 8'h8A);

        // Random frames against a byte/error queue model.
        got_q.delete();
        exp_q.delete();
        exp_fe = 0;
        f0 = fe_cnt; o0 = ov_cnt;
        for (int k = 0; k < 16; k++) begin
            int n;
            logic [7:0] d;
            logic stop;
            n = $urandom_range(4, 40);
            d = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            if (stop) exp_q.push_back(d);
            else exp_fe++;
            send_frame(d, stop, n, stop ? 0 : $urandom_range(0, 3 * n));
            wait_cyc($urandom_range(1, 6));
        end
        wait_cyc(4);
        check("rnd_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0) check_byte("rnd_data", exp_q.pop_front());
        check("rnd_fe", fe_cnt - f0, exp_fe);
        check("rnd_ovr", ov_cnt - o0, 0);

        check("fe_pulse_width", fe_wide, 0);
        check("ovr_pulse_width", ov_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usart_receiver.md
# usart_receiver

Byte-oriented USART receive front end for the comm clock domain. It synchronises `rx_pin` and detects the start bit by its falling edge. Each bit is sampled at mid-bit using a programmable `clocks_per_bit` divider, and each byte is delivered through a one-entry valid/ready holding register. It sits directly upstream of the echo/loopback and command logic, which consume `rx_data`, and it reports framing and overrun errors as single-cycle pulses.

## Interface
- `SYNC_STAGES`, 2, number of flops in the `rx_pin` synchroniser (≥2).
- `comm_clock`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clocks_per_bit`  in  12  `comm_clock` cycles per serial bit (N). Valid range is 4..4095. It is latched at start detect.
- `rx_pin`  in  1  serial line, idle high, 8N1, LSB first.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `rx_data`  out  8  received byte; stable while `rx_valid`.
- `rx_valid`  out  1  holding register full.
- `framing_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun_error`  out  1  one-cycle pulse when a completed byte is dropped.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchroniser flops reset to 1, and `rx_prev` (the previous synchronised value) resets to 1. `rx_sync` denotes the last synchroniser stage.
- FSM states are IDLE, START, DATA, STOP and BREAK. The FSM holds a 12-bit down-counter `cnt`, a 3-bit `bit_idx` and an 8-bit `shift`.
- **IDLE**
  - Start detect is `rx_prev==1 && rx_sync==0`.
  - On start detect: go to START, `cnt <= N>>1`, latch N.
- **Timed states (START, DATA, STOP)**, evaluated every edge:
  - If `cnt!=0`: `cnt <= cnt-1`.
  - Otherwise take a sample and reload `cnt <= N-1`, giving a sample period of exactly N cycles.
- **START sample**
  - `rx_sync==0`: go to DATA with `bit_idx=0`.
  - `rx_sync==1`: false start; return to IDLE. No output, no error.
- **DATA sample**
  - `shift <= {rx_sync, shift[7:1]}`.
  - After `bit_idx==7` go to STOP; otherwise `bit_idx++`.
- **STOP sample, `rx_sync==1`**: deliver `shift` to the holding register, then go to IDLE.
- **STOP sample, `rx_sync==0`**: pulse `framing_error`, discard the byte, go to BREAK.
- **BREAK**: wait for `rx_sync==1`, then go to IDLE. No new start is detected until the line has returned high.
- **Holding register**
  - Transfer happens when `rx_valid && rx_ready`; `rx_valid` clears on the next edge.
  - Delivery in the same cycle as a transfer is legal: the new byte loads and `rx_valid` stays high.
  - Delivery while full and not transferring: pulse `overrun_error`, drop the new byte, leave `rx_data` unchanged.
- `rx_ready` while `rx_valid==0` has no effect.
- `clocks_per_bit` changes take effect only at the next start detect.

## Timing
- **Reset values**
  - `rx_data=0`, `rx_valid=0`, `framing_error=0`, `overrun_error=0`, `busy=0`.
  - State IDLE, `cnt=0`, `bit_idx=0`, `shift=0`.
- **Reset mid-frame** (`reset_n` low at any point) immediately forces all of the above values. Any partial byte or held byte is lost.
- **Start-detect latency**, with edge 0 defined as the first rising edge at which `rx_pin` is low (`SYNC_STAGES=2`):
  - START is entered at edge 2.
  - The start sample occurs at edge 3+N/2.
  - Data bit i is sampled at edge 3+N/2+N(i+1).
  - The stop bit is sampled at edge 3+N/2+9N.
- **Output latency**: `rx_valid` (or `framing_error`) is high in the cycle following the stop sample. For N=64 this is 611 cycles after edge 0.
- **Error pulses** are exactly one cycle wide.
- **Glitch filtering**: a low glitch shorter than about N/2−2 cycles is rejected at the START sample.
- **`busy`** rises with START entry and falls on the edge entering IDLE.

## Test plan
- **Reset**
  - Stimulus: hold `reset_n` low with `rx_pin=0`, then release with `rx_pin=1` and wait 2000 cycles.
  - Required: all outputs 0 throughout, with no `rx_valid` and no `busy`.
- **Single frame**
  - Stimulus: N=64 (128 ns bits at a 2 ns clock), `rx_ready=1`; send bits LSB-first 1,0,1,0,1,1,1,0 with a stop bit of 1.
  - Required: `rx_valid` high for exactly one cycle with `rx_data=0x75`, at 611±1 cycles after edge 0. No error pulses.
- **Overrun**
  - Stimulus: `rx_ready=0`; send 0x75, then 0x8A (bits 0,1,0,1,0,0,0,1), then raise `rx_ready`.
  - Required: `overrun_error` pulses once, at the 0x8A stop sample, while `rx_data` stays 0x75.
  - Required: after `rx_ready` rises, `rx_valid` drops on the next edge.
- **Glitch rejection**
  - Stimulus: N=64; drive `rx_pin` low for 10 cycles, then high.
  - Required: `busy` pulses, then returns to 0 within 40 cycles, with no `rx_valid` and no error pulse.
- **Framing error and break**
  - Stimulus: send 0x75 with the stop bit 0, hold the line low for 20N, raise it, then send 0x8A.
  - Required: a single `framing_error` pulse and no `rx_valid` for the first frame; no activity during the break; then `rx_data=0x8A` with `rx_valid` high.
- **Reset mid-frame**
  - Stimulus: pulse `reset_n` low during data bit 4 of a frame, with the line high after release; then send 0x8A.
  - Required: outputs cleared, no spurious byte, then `rx_data=0x8A` received correctly.
